// File: rtl/phy_pkg.sv
// ============================================================================
// Module      : phy_pkg
// Description : Shared definitions for the two-lane serial PHY (rx and tx).
//               Holds the comma character, the number of consecutive commas
//               needed for lane alignment and the lane FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package phy_pkg;

  // Alignment / idle character carried on every lane.
  localparam logic [7:0] COMMA       = 8'hBC;

  // Consecutive commas (including the one that locks the boundary) required
  // before a lane is declared active.
  localparam int         SYNC_COMMAS = 4;

  // Lane alignment state machine encoding.
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } lane_state_e;

  function automatic logic is_comma_byte(input logic [7:0] b);
    return (b == COMMA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/phy_rx_if.sv
// ============================================================================
// Module      : phy_rx_if
// Description : Serial-lane / reassembled-word bundle of the PHY receiver.
//   in_rx_serial_0/1 : lane serial data, MSB first (master -> slave)
//   data_out[31:0]   : reassembled word, held between words (slave -> master)
//   validOut         : one-clk pulse on a new word (slave -> master)
//   active           : both lanes aligned (slave -> master)
//   err_count[7:0]   : saturating framing error count (slave -> master)
// Modports    : master = serial source / word consumer, slave = phy_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface phy_rx_if;

  logic        in_rx_serial_0;
  logic        in_rx_serial_1;
  logic [31:0] data_out;
  logic        validOut;
  logic        active;
  logic [7:0]  err_count;

  modport master (
    output in_rx_serial_0,
    output in_rx_serial_1,
    input  data_out,
    input  validOut,
    input  active,
    input  err_count
  );

  modport slave (
    input  in_rx_serial_0,
    input  in_rx_serial_1,
    output data_out,
    output validOut,
    output active,
    output err_count
  );

endinterface

`default_nettype wire

// File: rtl/phy_rx_lane.sv
// ============================================================================
// Module      : phy_rx_lane
// Description : One receive lane. Shifts serial bits (MSB first) into an
//               8-bit window, locks the byte boundary on a comma and declares
//               the lane active after SYNC_COMMAS consecutive commas.
// Ports       :
//   clk, reset      : bit clock, asynchronous active-high reset
//   i_serial        : serial lane input
//   o_byte[7:0]     : last byte completed at a byte boundary
//   o_byte_strobe   : one-clk pulse when o_byte / o_is_comma are updated
//   o_is_comma      : o_byte equals the comma character
//   o_lane_active   : lane reached ACTIVE (held until reset)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phy_rx_lane
  import phy_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_serial,
  output logic [7:0] o_byte,
  output logic       o_byte_strobe,
  output logic       o_is_comma,
  output logic       o_lane_active
);

  lane_state_e r_state;
  lane_state_e w_state_next;

  logic [7:0]  r_window;
  logic [2:0]  r_bit_cnt;
  logic [2:0]  r_comma_cnt;
  logic [7:0]  r_byte;
  logic        r_strobe;
  logic        r_is_comma;

  logic [7:0]  w_window_next;
  logic        w_window_comma;
  logic        w_boundary;
  logic [2:0]  w_bit_cnt_next;
  logic [2:0]  w_comma_cnt_next;
  logic        w_strobe;

  // The window seen at this edge already includes the incoming bit, so a
  // byte is complete on the same edge that samples its last (LSB) bit.
  assign w_window_next  = {r_window[6:0], i_serial};
  assign w_window_comma = is_comma_byte(w_window_next);
  // Counter value 7 means this edge delivers the 8th bit since the boundary.
  assign w_boundary     = (r_bit_cnt == 3'd7);

  always_comb begin
    w_state_next     = r_state;
    w_bit_cnt_next   = r_bit_cnt + 3'd1;
    w_comma_cnt_next = r_comma_cnt;
    w_strobe         = 1'b0;

    case (r_state)
      SEARCH: begin
        if (w_window_comma) begin
          w_bit_cnt_next   = 3'd0;
          w_comma_cnt_next = 3'd1;
          w_state_next     = SYNC;
        end
      end

      SYNC: begin
        if (w_boundary) begin
          w_strobe = 1'b1;
          if (w_window_comma) begin
            w_comma_cnt_next = r_comma_cnt + 3'd1;
            if (r_comma_cnt == 3'(SYNC_COMMAS - 1)) begin
              w_state_next = ACTIVE;
            end
          end else begin
            w_comma_cnt_next = 3'd0;
            w_state_next     = SEARCH;
          end
        end
      end

      ACTIVE: begin
        // No loss-of-sync detection: the lane stays here until reset.
        if (w_boundary) begin
          w_strobe = 1'b1;
        end
      end

      default: begin
        w_state_next     = SEARCH;
        w_comma_cnt_next = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= SEARCH;
      r_window    <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_comma_cnt <= 3'd0;
      r_byte      <= 8'h00;
      r_strobe    <= 1'b0;
      r_is_comma  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_window    <= w_window_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_comma_cnt <= w_comma_cnt_next;
      r_strobe    <= w_strobe;
      if (w_strobe) begin
        r_byte     <= w_window_next;
        r_is_comma <= w_window_comma;
      end
    end
  end

  assign o_byte        = r_byte;
  assign o_byte_strobe = r_strobe;
  assign o_is_comma    = r_is_comma;
  assign o_lane_active = (r_state == ACTIVE);

endmodule

`default_nettype wire

// File: rtl/phy_rx.sv
// ============================================================================
// Module      : phy_rx
// Description : Two-lane serial PHY receiver. Aligns each lane on commas,
//               then reassembles 32-bit words from two consecutive byte
//               pairs (lane0 carries bytes 3/1, lane1 carries bytes 2/0).
// Ports       :
//   clk     : serial bit clock
//   reset   : asynchronous active-high reset
//   rx      : phy_rx_if.slave (serial lanes in; data_out, validOut, active,
//             err_count out)
// Config      : PHY_RX_ERR_CNT_EN - when defined, err_count counts framing
//               errors (saturating at 255); otherwise it stays 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phy_rx
  import phy_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  phy_rx_if.slave rx
);

`ifdef PHY_RX_ERR_CNT_EN
  localparam bit c_err_cnt_en = 1'b1;
`else
  localparam bit c_err_cnt_en = 1'b0;
`endif

  logic       w_serial      [2];
  logic [7:0] w_byte        [2];
  logic       w_strobe      [2];
  logic       w_is_comma    [2];
  logic       w_lane_active [2];

  logic        r_active;
  logic        r_phase;
  logic [15:0] r_upper;
  logic [31:0] r_data;
  logic        r_valid;
  logic [7:0]  r_err_cnt;

  logic w_pair;
  logic w_both_comma;
  logic w_one_comma;
  logic w_frame_err;

  assign w_serial[0] = rx.in_rx_serial_0;
  assign w_serial[1] = rx.in_rx_serial_1;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    phy_rx_lane u_lane (
      .clk           (clk),
      .reset         (reset),
      .i_serial      (w_serial[g]),
      .o_byte        (w_byte[g]),
      .o_byte_strobe (w_strobe[g]),
      .o_is_comma    (w_is_comma[g]),
      .o_lane_active (w_lane_active[g])
    );
  end

  // Lanes are launched together, so their strobes coincide; requiring both
  // keeps a byte pair from being split across two boundaries.
  assign w_pair       = r_active & w_strobe[0] & w_strobe[1];
  assign w_both_comma = w_is_comma[0] & w_is_comma[1];
  assign w_one_comma  = w_is_comma[0] ^ w_is_comma[1];
  // Mixed comma/data pair, or idle arriving with only half a word stored.
  assign w_frame_err  = w_pair & (w_one_comma | (w_both_comma & r_phase));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active  <= 1'b0;
      r_phase   <= 1'b0;
      r_upper   <= 16'h0000;
      r_data    <= 32'h0000_0000;
      r_valid   <= 1'b0;
      r_err_cnt <= 8'h00;
    end else begin
      r_valid  <= 1'b0;
      // Registered AND: active rises one clk after the last lane locks,
      // which also keeps phase at 0 until the first pair seen while active.
      r_active <= w_lane_active[0] & w_lane_active[1];

      if (w_pair) begin
        if (!w_is_comma[0] && !w_is_comma[1]) begin
          if (!r_phase) begin
            r_upper <= {w_byte[0], w_byte[1]};
            r_phase <= 1'b1;
          end else begin
            r_data  <= {r_upper, w_byte[0], w_byte[1]};
            r_valid <= 1'b1;
            r_phase <= 1'b0;
          end
        end else begin
          // Idle or framing error: any partial word is dropped.
          r_upper <= 16'h0000;
          r_phase <= 1'b0;
        end
      end

      if (c_err_cnt_en && w_frame_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign rx.data_out  = r_data;
  assign rx.validOut  = r_valid;
  assign rx.active    = r_active;
  assign rx.err_count = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_phy_rx.sv
// ============================================================================
// Module      : tb_phy_rx
// Description : Self-checking bench for phy_rx. Drives both lanes bit by bit,
//               logs DUT outputs after every rising edge, and compares the
//               log against a vector table, hand sequences and a byte-level
//               reference model fed with random byte pairs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phy_rx;
  import phy_pkg::*;

  localparam int LOG_DEPTH = 16384;
  localparam int N_RAND    = 240;

`ifdef PHY_RX_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  phy_rx_if bus ();

  phy_rx dut (
    .clk   (clk),
    .reset (reset),
    .rx    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;

  logic        log_valid  [LOG_DEPTH];
  logic        log_active [LOG_DEPTH];
  logic [31:0] log_data   [LOG_DEPTH];

  // Entry k holds the outputs seen just after rising edge number k.
  initial begin
    forever begin
      @(posedge clk);
      ncyc++;
      #1;
      if (ncyc < LOG_DEPTH) begin
        log_valid[ncyc]  = bus.validOut;
        log_active[ncyc] = bus.active;
        log_data[ncyc]   = bus.data_out;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic lv(input int k);
    return (k >= 0 && k < LOG_DEPTH) ? log_valid[k] : 1'bx;
  endfunction

  function automatic logic [31:0] ld(input int k);
    return (k >= 0 && k < LOG_DEPTH) ? log_data[k] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic la(input int k);
    return (k >= 0 && k < LOG_DEPTH) ? log_active[k] : 1'bx;
  endfunction

  function automatic int count_valid(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (lv(k) === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_active(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (la(k) !== 1'b0) n++;
    return n;
  endfunction

  function automatic logic [31:0] exp_err(input int n);
    if (!ERR_EN) return 32'd0;
    return (n > 255) ? 32'd255 : 32'(n);
  endfunction

  function automatic logic [7:0] rand_data();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (v == COMMA) v = 8'h3C;
    return v;
  endfunction

  // Drive one byte per lane, MSB first; 'last' is the edge sampling the LSB.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, output int last);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      bus.in_rx_serial_0 = a[i];
      bus.in_rx_serial_1 = b[i];
      last = ncyc + 1;
    end
  endtask

  task automatic send_offset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_rx_serial_0 = 1'($urandom_range(0, 1));
      bus.in_rx_serial_1 = bus.in_rx_serial_0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_rx_serial_0 = 1'b0;
    bus.in_rx_serial_1 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // 3-bit offset then 4 commas; a 5th comma keeps the stream going while
  // the edge after the 4th comma is logged.
  task automatic align_and_check(input string tag);
    int first, e4, dummy;
    first = ncyc + 1;
    send_offset(3);
    for (int k = 0; k < 4; k++) send_pair(COMMA, COMMA, e4);
    send_pair(COMMA, COMMA, dummy);
    check({tag, "_active_early"}, 32'(count_active(first, e4)), 32'd0);
    check({tag, "_active_rise"}, {31'd0, la(e4 + 1)}, 32'd1);
    check({tag, "_no_valid"}, 32'(count_valid(first, e4 + 8)), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [13];
  vec_t tb2 [5];
  int   last_t [13];
  int   last_2 [5];

  logic [7:0]  rb0 [N_RAND];
  logic [7:0]  rb1 [N_RAND];
  logic        rexp_v [N_RAND];
  logic [31:0] rexp_d [N_RAND];
  int          last_r [N_RAND];

  initial begin
    int e, dummy, first, p1, p2, pc, m_err, m_words;
    bit m_half;
    logic [15:0] m_up;
    logic [31:0] m_out;

    tbl[0]  = '{8'hBC, 8'hBC, 1'b0, 32'h0000_0000};
    tbl[1]  = '{8'hDE, 8'hAD, 1'b0, 32'h0000_0000};
    tbl[2]  = '{8'hBE, 8'hEF, 1'b1, 32'hDEAD_BEEF};
    tbl[3]  = '{8'hBC, 8'hBC, 1'b0, 32'hDEAD_BEEF};
    tbl[4]  = '{8'h01, 8'h23, 1'b0, 32'hDEAD_BEEF};
    tbl[5]  = '{8'h45, 8'h67, 1'b1, 32'h0123_4567};
    tbl[6]  = '{8'h89, 8'hAB, 1'b0, 32'h0123_4567};
    tbl[7]  = '{8'hCD, 8'hEF, 1'b1, 32'h89AB_CDEF};
    tbl[8]  = '{8'hBC, 8'hBC, 1'b0, 32'h89AB_CDEF};
    tbl[9]  = '{8'hBC, 8'h12, 1'b0, 32'h89AB_CDEF};
    tbl[10] = '{8'h11, 8'h22, 1'b0, 32'h89AB_CDEF};
    tbl[11] = '{8'hBC, 8'hBC, 1'b0, 32'h89AB_CDEF};
    tbl[12] = '{8'hBC, 8'hBC, 1'b0, 32'h89AB_CDEF};

    // After a mid-word reset: a lone pair then idle must not emit anything.
    tb2[0] = '{8'h77, 8'h88, 1'b0, 32'h0000_0000};
    tb2[1] = '{8'hBC, 8'hBC, 1'b0, 32'h0000_0000};
    tb2[2] = '{8'h33, 8'h44, 1'b0, 32'h0000_0000};
    tb2[3] = '{8'h55, 8'h66, 1'b1, 32'h3344_5566};
    tb2[4] = '{8'hBC, 8'hBC, 1'b0, 32'h3344_5566};

    // ---------------- reset state ----------------
    reset = 1'b1;
    bus.in_rx_serial_0 = 1'b0;
    bus.in_rx_serial_1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", bus.data_out, 32'd0);
    check("rst_validOut", {31'd0, bus.validOut}, 32'd0);
    check("rst_active", {31'd0, bus.active}, 32'd0);
    check("rst_err_count", {24'd0, bus.err_count}, 32'd0);
    reset = 1'b0;

    // ---------------- alignment + vector table ----------------
    align_and_check("align0");
    for (int i = 0; i < 13; i++) send_pair(tbl[i].b0, tbl[i].b1, last_t[i]);

    // Mid-word reset: first pair of a word, then reset once it is stored.
    send_pair(8'h11, 8'h22, dummy);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("tbl_err_count", {24'd0, bus.err_count}, exp_err(2));
    check("pre_rst_data", bus.data_out, 32'h89AB_CDEF);
    reset = 1'b1;
    #1;
    check("midrst_data_out", bus.data_out, 32'd0);
    check("midrst_validOut", {31'd0, bus.validOut}, 32'd0);
    check("midrst_active", {31'd0, bus.active}, 32'd0);
    check("midrst_err_count", {24'd0, bus.err_count}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      check($sformatf("tbl%0d_valid", i), {31'd0, lv(last_t[i] + 1)}, {31'd0, tbl[i].exp_valid});
      check($sformatf("tbl%0d_data", i), ld(last_t[i] + 1), tbl[i].exp_data);
    end
    check("tbl_pulse_count", 32'(count_valid(last_t[0], last_t[12] + 1)), 32'd3);
    p1 = -1;
    p2 = -1;
    pc = 0;
    for (int k = last_t[0]; k <= last_t[12] + 1; k++) begin
      if (lv(k) === 1'b1) begin
        pc++;
        if (pc == 2) p1 = k;
        if (pc == 3) p2 = k;
      end
    end
    check("b2b_spacing", 32'(p2 - p1), 32'd16);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    align_and_check("realign");
    for (int i = 0; i < 5; i++) send_pair(tb2[i].b0, tb2[i].b1, last_2[i]);
    @(posedge clk);
    @(posedge clk);
    #2;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("post_rst%0d_valid", i), {31'd0, lv(last_2[i] + 1)}, {31'd0, tb2[i].exp_valid});
      check($sformatf("post_rst%0d_data", i), ld(last_2[i] + 1), tb2[i].exp_data);
    end
    check("post_rst_pulses", 32'(count_valid(last_2[0], last_2[4] + 1)), 32'd1);
    check("post_rst_err", {24'd0, bus.err_count}, exp_err(1));

    // ---------------- broken sync ----------------
    do_reset();
    first = ncyc + 1;
    send_pair(COMMA, COMMA, dummy);
    send_pair(COMMA, COMMA, dummy);
    send_pair(8'h55, 8'h55, dummy);
    for (int k = 0; k < 4; k++) send_pair(COMMA, COMMA, e);
    send_pair(COMMA, COMMA, dummy);
    check("brk_active_low", 32'(count_active(first, e)), 32'd0);
    check("brk_active_rise", {31'd0, la(e + 1)}, 32'd1);

    // ---------------- random pairs vs byte-level model ----------------
    do_reset();
    align_and_check("align_rand");
    for (int i = 0; i < N_RAND; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (i == N_RAND - 1 || kind < 2) begin
        rb0[i] = COMMA;
        rb1[i] = COMMA;
      end else if (kind == 2) begin
        rb0[i] = COMMA;
        rb1[i] = rand_data();
      end else if (kind == 3) begin
        rb0[i] = rand_data();
        rb1[i] = COMMA;
      end else begin
        rb0[i] = rand_data();
        rb1[i] = rand_data();
      end
    end

    // Words are formed from consecutive data pairs; an idle or mixed pair
    // ends any word in progress (counted as an error if it broke one).
    m_half  = 1'b0;
    m_up    = 16'h0;
    m_out   = 32'h0;
    m_err   = 0;
    m_words = 0;
    for (int i = 0; i < N_RAND; i++) begin
      bit c0, c1;
      c0 = (rb0[i] == COMMA);
      c1 = (rb1[i] == COMMA);
      rexp_v[i] = 1'b0;
      if (c0 != c1 || (c0 && c1 && m_half)) m_err++;
      if (c0 || c1) begin
        m_half = 1'b0;
      end else if (!m_half) begin
        m_up   = {rb0[i], rb1[i]};
        m_half = 1'b1;
      end else begin
        m_out     = {m_up, rb0[i], rb1[i]};
        rexp_v[i] = 1'b1;
        m_half    = 1'b0;
        m_words++;
      end
      rexp_d[i] = m_out;
    end

    for (int i = 0; i < N_RAND; i++) send_pair(rb0[i], rb1[i], last_r[i]);
    @(posedge clk);
    @(posedge clk);
    #2;
    for (int i = 0; i < N_RAND; i++) begin
      check($sformatf("rand%0d_valid", i), {31'd0, lv(last_r[i] + 1)}, {31'd0, rexp_v[i]});
      check($sformatf("rand%0d_data", i), ld(last_r[i] + 1), rexp_d[i]);
    end
    check("rand_pulses", 32'(count_valid(last_r[0], last_r[N_RAND - 1] + 1)), 32'(m_words));
    check("rand_err_count", {24'd0, bus.err_count}, exp_err(m_err));
    check("rand_active_hold", {31'd0, bus.active}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
